// File: rtl/glyph_row_writer.sv
// Packs a serial left-to-right pixel stream into ROW_W-bit row words and writes one glyph (ROWS rows) to glyph RAM.
// Define GLYPH_ROW_WRITER_MIRROR_EN to pack LSB-first and store the glyph horizontally mirrored.
module glyph_row_writer #(
    parameter int ROW_W  = 16,
    parameter int ROWS   = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              bit_in,
    input  logic              bit_valid,
    output logic              bit_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ROW_W-1:0]  wr_data,
    output logic              busy,
    output logic              done
);

    localparam int BIT_CW = $clog2(ROW_W);
    localparam int ROW_CW = $clog2(ROWS);

    typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

    state_t              state;
    state_t              next_state;
    logic [BIT_CW-1:0]   bit_cnt;
    logic [ROW_CW-1:0]   row_cnt;
    logic [ROW_W-1:0]    shift_reg;
    logic [ADDR_W-1:0]   base_q;
    logic                last_bit;
    logic                last_row;

    assign last_bit = (bit_cnt == BIT_CW'(ROW_W - 1));
    assign last_row = (row_cnt == ROW_CW'(ROWS - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = LOAD;
            LOAD:    if (bit_valid && last_bit) next_state = WRITE;
            WRITE:   next_state = last_row ? DONE : LOAD;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath: counters, packing shift register and the latched base address.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt   <= '0;
            row_cnt   <= '0;
            shift_reg <= '0;
            base_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        base_q    <= base_addr;
                        bit_cnt   <= '0;
                        row_cnt   <= '0;
                        shift_reg <= '0;
                    end
                end
                LOAD: begin
                    if (bit_valid) begin
`ifdef GLYPH_ROW_WRITER_MIRROR_EN
                        shift_reg <= {bit_in, shift_reg[ROW_W-1:1]};
`else
                        shift_reg <= {shift_reg[ROW_W-2:0], bit_in};
`endif
                        if (!last_bit) begin
                            bit_cnt <= bit_cnt + BIT_CW'(1);
                        end
                    end
                end
                WRITE: begin
                    bit_cnt <= '0;
                    if (!last_row) begin
                        row_cnt <= row_cnt + ROW_CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Write port is driven only in WRITE so it reads zero whenever no write is in flight.
    always_comb begin
        bit_ready = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            LOAD: begin
                bit_ready = 1'b1;
                busy      = 1'b1;
            end
            WRITE: begin
                wr_en   = 1'b1;
                wr_addr = base_q + ADDR_W'(row_cnt);
                wr_data = shift_reg;
                busy    = 1'b1;
            end
            DONE: begin
                done = 1'b1;
                busy = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_glyph_row_writer.sv
// Directed-plus-random bench for glyph_row_writer; expected RAM writes come from a row/address model of the glyph.
// Honours GLYPH_ROW_WRITER_MIRROR_EN when computing expected row words.
module tb_glyph_row_writer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  base_addr = '0;
    logic        bit_in = 1'b0;
    logic        bit_valid = 1'b0;
    logic        bit_ready;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [15:0] wr_data;
    logic        busy;
    logic        done;

    int passed = 0;
    int total = 0;
    int cyc = 0;
    int done_cnt = 0;
    int consec_wr = 0;
    logic prev_wr = 1'b0;
    logic [15:0] first_row_data;

    glyph_row_writer #(.ROW_W(16), .ROWS(16), .ADDR_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(bit_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse and back-to-back write monitors, sampled mid-cycle.
    always @(negedge clk) begin
        if (done) done_cnt = done_cnt + 1;
        if (wr_en && prev_wr) consec_wr = consec_wr + 1;
        prev_wr = wr_en;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [15:0] expected_word(input logic [15:0] pixels);
        logic [15:0] w;
`ifdef GLYPH_ROW_WRITER_MIRROR_EN
        for (int i = 0; i < 16; i++) w[i] = pixels[15 - i];
`else
        w = pixels;
`endif
        return w;
    endfunction

    task automatic run_glyph(input logic [7:0] base, input logic [15:0] rows [16],
                             input bit gaps, input bit poke_start);
        int start_cyc;
        int done_before;
        logic [7:0] exp_addr;
        done_before = done_cnt;
        check("idle_ready", 32'(bit_ready), 32'd0);
        base_addr = base;
        start = 1'b1;
        step();
        start = 1'b0;
        base_addr = 8'($urandom);
        start_cyc = cyc;
        for (int r = 0; r < 16; r++) begin
            for (int i = 0; i < 16; i++) begin
                if (gaps) begin
                    bit_valid = 1'b0;
                    bit_in = 1'($urandom);
                    step();
                end
                bit_valid = 1'b1;
                bit_in = rows[r][15 - i];
                if (poke_start && r == 2 && i == 3) begin
                    start = 1'b1;
                    base_addr = 8'h40;
                end
                if (i == 0) check("load_ready", 32'(bit_ready), 32'd1);
                step();
                start = 1'b0;
            end
            bit_valid = 1'b0;
            bit_in = 1'b0;
            exp_addr = 8'((int'(base) + r) % 256);
            check($sformatf("wr_en_row%0d", r), 32'(wr_en), 32'd1);
            check($sformatf("wr_addr_row%0d", r), 32'(wr_addr), 32'(exp_addr));
            check($sformatf("wr_data_row%0d", r), 32'(wr_data), 32'(expected_word(rows[r])));
            check($sformatf("write_ready_row%0d", r), 32'(bit_ready), 32'd0);
            if (r == 0) begin
                first_row_data = wr_data;
                if (!gaps) check("first_write_cycle", 32'(cyc - start_cyc + 1), 32'd17);
            end
            step();
        end
        check("done_pulse", 32'(done), 32'd1);
        check("done_busy", 32'(busy), 32'd1);
        if (!gaps) check("done_cycle", 32'(cyc - start_cyc + 1), 32'd273);
        step();
        check("idle_done", 32'(done), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("done_count", 32'(done_cnt - done_before), 32'd1);
        check("no_consec_wr", 32'(consec_wr), 32'd0);
    endtask

    initial begin
        logic [15:0] rows [16];

        $display("[TB] glyph_row_writer bench starting");
        #2;
        check("rst_ready", 32'(bit_ready), 32'd0);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        step();
        reset = 1'b0;
        step();

        // Reset mid-LOAD after five foreground bits.
        base_addr = 8'h20;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bit_valid = 1'b1;
            bit_in = 1'b1;
            step();
        end
        bit_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("midrst_ready", 32'(bit_ready), 32'd0);
        check("midrst_wr_en", 32'(wr_en), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        step();
        reset = 1'b0;
        step();
        for (int r = 0; r < 16; r++) rows[r] = (r == 0) ? 16'h0000 : 16'($urandom);
        run_glyph(8'h20, rows, 1'b0, 1'b0);

        // Single row timing and constant with 16'd120 as row 0.
        for (int r = 0; r < 16; r++) rows[r] = 16'($urandom);
        rows[0] = 16'd120;
        run_glyph(8'h10, rows, 1'b0, 1'b0);
`ifdef GLYPH_ROW_WRITER_MIRROR_EN
        check("row120_const", 32'(first_row_data), 32'h1E00);
`else
        check("row120_const", 32'(first_row_data), 32'h0078);
`endif

        // Walking pixel with bit_valid gaps.
        for (int r = 0; r < 16; r++) rows[r] = 16'h8000 >> r;
        run_glyph(8'h33, rows, 1'b1, 1'b0);

        // Address wrap.
        for (int r = 0; r < 16; r++) rows[r] = 16'($urandom);
        run_glyph(8'hF8, rows, 1'b0, 1'b0);

        // Start pulsed while busy.
        for (int r = 0; r < 16; r++) rows[r] = 16'($urandom);
        run_glyph(8'h80, rows, 1'b0, 1'b1);

        // Random glyphs, back-to-back restart the cycle after DONE.
        for (int g = 0; g < 3; g++) begin
            for (int r = 0; r < 16; r++) rows[r] = 16'($urandom);
            run_glyph(8'($urandom), rows, 1'($urandom), 1'b0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
